// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram_like responder.
//   SZ_*          : size_i encodings (2'b11 behaves as a word access)
//   state_e       : responder FSM states
//   byte_mask     : byte write enables from size and addr[1:0]
//   is_misaligned : half on an odd byte, or word not on a word boundary
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: byte_mask = 4'b0001 << a;
      SZ_HALF: byte_mask = a[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/d_sram_like_resp_if.sv
// sram_like request/response bus.
//   master : requester side (drives req/wr/size/addr/wdata)
//   slave  : responder side (drives addr_ok/data_ok/rdata)
interface d_sram_like_resp_if;
  logic        req_i;
  logic        wr_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        addr_ok_o;
  logic        data_ok_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i, wr_i, size_i, addr_i, wdata_i,
    input  addr_ok_o, data_ok_o, rdata_o
  );

  modport slave (
    input  req_i, wr_i, size_i, addr_i, wdata_i,
    output addr_ok_o, data_ok_o, rdata_o
  );
endinterface

// File: rtl/d_sram_like_resp_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1), advances every cycle.
//   i_clk : clock
//   i_rst : asynchronous active-high reset, reloads SEED
//   o_rnd : two low-order bits of the current LFSR value
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [1:0] o_rnd
);
  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign o_rnd = r_lfsr[1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= SEED;
    else       r_lfsr <= {r_lfsr[6:0], w_fb};
  end
endmodule

// File: rtl/d_sram_like_resp.sv
// sram_like slave that fronts a synchronous SRAM, one transaction at a time.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : sram_like request/response (slave modport)
//   misalign_o   : sticky, set when a misaligned request is accepted
//   mem_*        : backing SRAM port; read data arrives the cycle after mem_en_o
module d_sram_like_resp
  import sram_like_pkg::*;
#(
  parameter int unsigned ADDR_LAT = 0,
  parameter int unsigned DATA_LAT = 2,
  parameter int unsigned RAND_EN  = 0,
  parameter int unsigned MEM_AW   = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  d_sram_like_resp_if.slave bus,
  output logic              misalign_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);
  localparam logic [3:0] ACNT_TGT  = 4'(ADDR_LAT);
  localparam logic [4:0] DCNT_BASE = 5'(DATA_LAT - 2);
  localparam logic       AOK_IDLE  = (ADDR_LAT == 0);

  state_e            r_state;
  logic [3:0]        r_acnt;
  logic [4:0]        r_dcnt;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [1:0]        r_addr_lo;
  logic [MEM_AW-1:0] r_word;
  logic [31:0]       r_wdata;
  logic              r_addr_ok;
  logic              r_data_ok;
  logic              r_mem_en;
  logic [3:0]        r_mem_we;
  logic [31:0]       r_rdata;
  logic              r_misalign;

  logic [1:0]        w_rnd;
  logic              w_hs;
  logic [4:0]        w_dcnt_load;
  logic [3:0]        w_in_mask;
  logic [3:0]        w_lat_mask;

  lfsr8 #(.SEED(8'hA5)) u_lfsr (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .o_rnd (w_rnd)
  );

  // r_addr_ok is only ever set while idle, so this is the accept condition
  assign w_hs        = bus.req_i & r_addr_ok;
  assign w_dcnt_load = DCNT_BASE + ((RAND_EN != 0) ? {3'b000, w_rnd} : 5'd0);
  assign w_in_mask   = byte_mask(bus.size_i, bus.addr_i[1:0]);
  assign w_lat_mask  = byte_mask(r_size, r_addr_lo);

  assign bus.addr_ok_o = r_addr_ok;
  assign bus.data_ok_o = r_data_ok;
  // Read data is forwarded straight from the SRAM during RESP; hold register otherwise
  assign bus.rdata_o   = (r_state == ST_RESP && !r_wr) ? mem_rdata_i : r_rdata;
  assign misalign_o    = r_misalign;
  assign mem_en_o      = r_mem_en;
  assign mem_we_o      = r_mem_we;
  assign mem_addr_o    = r_word;
  assign mem_wdata_o   = r_wdata;

  // Outputs are registered: each transition loads the value for the state entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_acnt     <= '0;
      r_dcnt     <= '0;
      r_wr       <= 1'b0;
      r_size     <= '0;
      r_addr_lo  <= '0;
      r_word     <= '0;
      r_wdata    <= '0;
      r_addr_ok  <= AOK_IDLE;
      r_data_ok  <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= '0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_wr      <= bus.wr_i;
            r_size    <= bus.size_i;
            r_addr_lo <= bus.addr_i[1:0];
            r_word    <= bus.addr_i[MEM_AW+1:2];
            r_wdata   <= bus.wdata_i;
            r_acnt    <= '0;
            r_addr_ok <= 1'b0;
            r_dcnt    <= w_dcnt_load;
            if (is_misaligned(bus.size_i, bus.addr_i[1:0])) r_misalign <= 1'b1;
            if (w_dcnt_load != '0) begin
              r_state <= ST_WAIT;
            end else begin
              r_state  <= ST_ACCESS;
              r_mem_en <= 1'b1;
              r_mem_we <= bus.wr_i ? w_in_mask : 4'b0000;
            end
          end else if (bus.req_i) begin
            r_acnt    <= r_acnt + 4'd1;
            r_addr_ok <= (r_acnt + 4'd1 == ACNT_TGT);
          end else begin
            r_acnt    <= '0;
            r_addr_ok <= AOK_IDLE;
          end
        end
        ST_WAIT: begin
          r_dcnt <= r_dcnt - 5'd1;
          if (r_dcnt == 5'd1) begin
            r_state  <= ST_ACCESS;
            r_mem_en <= 1'b1;
            r_mem_we <= r_wr ? w_lat_mask : 4'b0000;
          end
        end
        ST_ACCESS: begin
          r_mem_en  <= 1'b0;
          r_mem_we  <= '0;
          r_data_ok <= 1'b1;
          r_state   <= ST_RESP;
        end
        ST_RESP: begin
          r_data_ok <= 1'b0;
          if (!r_wr) r_rdata <= mem_rdata_i;
          r_addr_ok <= AOK_IDLE;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_d_sram_like_resp.sv
// Bench for d_sram_like_resp: three instances with different latencies,
// a behavioural SRAM per instance, and a transaction-level reference model.
`timescale 1ns/1ps
module tb_d_sram_like_resp;
  localparam int unsigned NI = 3;
  localparam int unsigned AW = 12;

  function automatic int unsigned p_al(input int unsigned g); return (g == 2) ? 3 : 0; endfunction
  function automatic int unsigned p_dl(input int unsigned g); return (g == 0) ? 2 : (g == 1) ? 6 : 3; endfunction
  function automatic int unsigned p_re(input int unsigned g); return (g == 1) ? 1 : 0; endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req [NI];
  logic          wr [NI];
  logic [1:0]    size [NI];
  logic [31:0]   addr [NI];
  logic [31:0]   wdata [NI];
  logic          addr_ok [NI];
  logic          data_ok [NI];
  logic [31:0]   rdata [NI];
  logic          misalign [NI];
  logic          mem_en [NI];
  logic [3:0]    mem_we [NI];
  logic [AW-1:0] mem_addr [NI];
  logic [31:0]   mem_wdata [NI];
  logic [31:0]   mem_rdata [NI];

  d_sram_like_resp_if bus [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign bus[g].req_i   = req[g];
    assign bus[g].wr_i    = wr[g];
    assign bus[g].size_i  = size[g];
    assign bus[g].addr_i  = addr[g];
    assign bus[g].wdata_i = wdata[g];
    assign addr_ok[g]     = bus[g].addr_ok_o;
    assign data_ok[g]     = bus[g].data_ok_o;
    assign rdata[g]       = bus[g].rdata_o;

    d_sram_like_resp #(
      .ADDR_LAT (p_al(g)),
      .DATA_LAT (p_dl(g)),
      .RAND_EN  (p_re(g)),
      .MEM_AW   (AW)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus[g]),
      .misalign_o  (misalign[g]),
      .mem_en_o    (mem_en[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_rdata_i (mem_rdata[g])
    );
  end

  function automatic logic [31:0] init_word(input int unsigned i, input int unsigned w);
    if (i == 0 && w == 4) return 32'hDEADBEEF;
    return (32'h9E3779B9 * (w + 1)) ^ (i << 28);
  endfunction

  // Behavioural synchronous SRAM, preloaded on the first clock edge
  logic [31:0] sram [NI][1 << AW];
  logic [31:0] sram_nw;
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < NI; i++)
        for (int w = 0; w < 256; w++) sram[i][w] <= init_word(i, w);
      mem_loaded <= 1'b1;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (mem_en[i]) begin
          sram_nw = sram[i][mem_addr[i]];
          for (int b = 0; b < 4; b++)
            if (mem_we[i][b]) sram_nw[8*b +: 8] = mem_wdata[i][8*b +: 8];
          sram[i][mem_addr[i]] <= sram_nw;
          mem_rdata[i]         <= sram[i][mem_addr[i]];
        end
      end
    end
  end

  // Rising edges since reset release; the DUT LFSR has advanced this many times
  int unsigned cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Reference state
  logic [31:0] ref_mem [NI][256];
  logic        mis_exp [NI];
  logic [31:0] last_rd [NI];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_at(input int unsigned n);
    logic [7:0] v;
    v = 8'hA5;
    for (int unsigned s = 0; s < n; s++) v = {v[6:0], ^(v & 8'hB8)};
    return v;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return 4'(4'b0001 << a);
    if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic exp_mis(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return a[0];
    return a != 2'd0;
  endfunction

  // Entered right after a negedge with instance i idle. Holds the request until
  // accepted, scrambles the request inputs, then checks every cycle to completion.
  task automatic txn(input int unsigned i, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d, input bit keep);
    int unsigned wait_n, lat, ext;
    logic [3:0]  m;
    logic [7:0]  lv;
    logic [31:0] exp_rd;
    wr[i] = w; size[i] = sz; addr[i] = a; wdata[i] = d; req[i] = 1'b1;
    wait_n = 0;
    while (addr_ok[i] !== 1'b1 && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    chk($sformatf("i%0d.hs_wait", i), wait_n, p_al(i));
    if (wait_n >= 40) begin
      req[i] = 1'b0;
      return;
    end
    lv  = lfsr_at(cyc);
    ext = (p_re(i) != 0) ? 32'(lv[1:0]) : 0;
    lat = p_dl(i) + ext;
    m   = exp_mask(sz, a[1:0]);
    if (exp_mis(sz, a[1:0])) mis_exp[i] = 1'b1;
    exp_rd = ref_mem[i][a[9:2]];
    if (w)
      for (int b = 0; b < 4; b++)
        if (m[b]) ref_mem[i][a[9:2]][8*b +: 8] = d[8*b +: 8];
    @(negedge clk);
    wr[i] = 1'($urandom); size[i] = 2'($urandom); addr[i] = $urandom;
    wdata[i] = $urandom; req[i] = keep;
    for (int unsigned k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("i%0d.mem_en@%0d", i, k), 32'(mem_en[i]), 32'(k == lat - 1));
      chk($sformatf("i%0d.data_ok@%0d", i, k), 32'(data_ok[i]), 32'(k == lat));
      chk($sformatf("i%0d.addr_ok_busy@%0d", i, k), 32'(addr_ok[i]), 0);
      if (k == lat - 1) begin
        chk($sformatf("i%0d.mem_we", i), 32'(mem_we[i]), w ? 32'(m) : 0);
        chk($sformatf("i%0d.mem_addr", i), 32'(mem_addr[i]), 32'(a[13:2]));
        if (w) chk($sformatf("i%0d.mem_wdata", i), mem_wdata[i], d);
      end
      if (k == lat && !w) chk($sformatf("i%0d.rdata", i), rdata[i], exp_rd);
    end
    @(negedge clk);
    if (!w) last_rd[i] = exp_rd;
    chk($sformatf("i%0d.data_ok_end", i), 32'(data_ok[i]), 0);
    chk($sformatf("i%0d.rdata_hold", i), rdata[i], last_rd[i]);
    chk($sformatf("i%0d.misalign", i), 32'(misalign[i]), 32'(mis_exp[i]));
  endtask

  task automatic reset_checks(input string ph);
    for (int unsigned i = 0; i < NI; i++) begin
      chk($sformatf("%s.i%0d.addr_ok", ph, i), 32'(addr_ok[i]), 32'(p_al(i) == 0));
      chk($sformatf("%s.i%0d.data_ok", ph, i), 32'(data_ok[i]), 0);
      chk($sformatf("%s.i%0d.mem_en", ph, i), 32'(mem_en[i]), 0);
      chk($sformatf("%s.i%0d.mem_we", ph, i), 32'(mem_we[i]), 0);
      chk($sformatf("%s.i%0d.rdata", ph, i), rdata[i], 0);
      chk($sformatf("%s.i%0d.misalign", ph, i), 32'(misalign[i]), 0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < NI; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; size[i] = '0; addr[i] = '0; wdata[i] = '0;
      mis_exp[i] = 1'b0; last_rd[i] = '0;
      for (int unsigned w = 0; w < 256; w++) ref_mem[i][w] = init_word(i, w);
    end
    #1 rst = 1'b1;
    #1 reset_checks("por");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Instance 0: read, byte write, back-to-back reads, misaligned half write
    txn(0, 1'b0, 2'd2, 32'h0000_0010, 32'h0, 1'b0);
    txn(0, 1'b1, 2'd0, 32'h0000_0013, 32'hAB00_0000, 1'b0);
    txn(0, 1'b0, 2'd2, 32'h0000_0010, 32'h0, 1'b1);
    txn(0, 1'b0, 2'd2, 32'h0000_0014, 32'h0, 1'b0);
    txn(0, 1'b1, 2'd1, 32'h0000_0021, 32'h1234_5678, 1'b0);
    txn(0, 1'b0, 2'd2, 32'h0000_0020, 32'h0, 1'b0);

    // Instance 2: an interrupted request must restart the address-latency count
    @(negedge clk);
    req[2] = 1'b1;
    chk("i2.glitch0", 32'(addr_ok[2]), 0);
    @(negedge clk);
    chk("i2.glitch1", 32'(addr_ok[2]), 0);
    @(negedge clk);
    chk("i2.glitch2", 32'(addr_ok[2]), 0);
    req[2] = 1'b0;
    @(negedge clk);
    chk("i2.glitch3", 32'(addr_ok[2]), 0);
    txn(2, 1'b0, 2'd2, 32'h0000_0040, 32'h0, 1'b0);

    // Random traffic on every instance
    for (int unsigned i = 0; i < NI; i++) begin
      for (int n = 0; n < 30; n++) begin
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] ra;
        bit          kp;
        rw = 1'($urandom);
        rs = 2'($urandom);
        ra = $urandom & 32'hFFFF_C3FF;
        kp = ($urandom_range(0, 1) == 1);
        txn(i, rw, rs, ra, $urandom, kp);
        if (!kp) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      req[i] = 1'b0;
      @(negedge clk);
    end

    // Instance 1: reset while the transaction sits in WAIT
    @(negedge clk);
    wr[1] = 1'b1; size[1] = 2'd2; addr[1] = 32'h0000_0080; wdata[1] = 32'h5555_AAAA; req[1] = 1'b1;
    chk("i1.rst_hs", 32'(addr_ok[1]), 1);
    @(negedge clk);
    req[1] = 1'b0;
    chk("i1.rst_wait1", 32'(mem_en[1]), 0);
    @(negedge clk);
    chk("i1.rst_wait2", 32'(mem_en[1]), 0);
    #1 rst = 1'b1;
    #1 reset_checks("midrst");
    for (int unsigned i = 0; i < NI; i++) begin
      mis_exp[i] = 1'b0;
      last_rd[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("i1.post_rst_data_ok%0d", k), 32'(data_ok[1]), 0);
      chk($sformatf("i1.post_rst_mem_en%0d", k), 32'(mem_en[1]), 0);
    end
    txn(1, 1'b0, 2'd2, 32'h0000_0080, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
